// File: rtl/pc_stack_pkg.sv
// Shared defaults and action decode for the fetch-stage program counter with return-address stack.
// Holds the instantiation defaults for DataWidth, PCResetAddr, PCStep and RasDepth.
package pc_stack_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned PC_RESET_ADDR = 0;
    localparam int unsigned PC_STEP       = 1;
    localparam int unsigned RAS_DEPTH     = 8;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_CALL,
        ACT_RET,
        ACT_INC
    } pc_act_e;

    // Fixed priority: load > call > ret > inc > hold; a stall forces hold.
    function automatic pc_act_e pick_action(input logic en, input logic load,
                                            input logic call, input logic ret,
                                            input logic inc);
        pc_act_e act;
        act = ACT_HOLD;
        if (en) begin
            if (load)      act = ACT_LOAD;
            else if (call) act = ACT_CALL;
            else if (ret)  act = ACT_RET;
            else if (inc)  act = ACT_INC;
        end
        return act;
    endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: pushes are dropped when full and pops ignored when empty.
// Storage is not reset; only the depth counter is.
module ras_lifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CNTW-1:0]  depth_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNTW-1:0]  depth_q;
    logic [CNTW-1:0]  depth_d;
    logic             wr_en;

    always_comb begin
        depth_d = depth_q;
        wr_en   = 1'b0;
        if (push_i && !full_o) begin
            wr_en   = 1'b1;
            depth_d = depth_q + CNTW'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) depth_q <= '0;
        else         depth_q <= depth_d;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[AW'(depth_q)] <= data_i;
    end

    assign depth_o = depth_q;
    assign full_o  = (depth_q == CNTW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign top_o   = empty_o ? '0 : mem_q[AW'(depth_q - CNTW'(1))];

endmodule

// File: rtl/pc_stack.sv
// Fetch-stage program counter with jump, call/return via a hardware return-address stack,
// stall enable and sticky overflow/underflow flags.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int unsigned     WIDTH     = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PC_RESET_ADDR),
    parameter int unsigned     STEP      = PC_STEP,
    parameter int unsigned     DEPTH     = RAS_DEPTH,
    parameter int unsigned     CNTW      = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             load_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             inc_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] top_o,
    output logic [CNTW-1:0]  depth_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             unf_o
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push, pop;
    logic [WIDTH-1:0] ret_addr;
    pc_act_e          act;

    assign ret_addr = out_q + WIDTH'(STEP);

    // Clear first so a coincident error event wins over err_clr_i.
    always_comb begin
        act   = pick_action(en_i, load_i, call_i, ret_i, inc_i);
        out_d = out_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (err_clr_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        case (act)
            ACT_LOAD: out_d = in_i;
            ACT_CALL: begin
                out_d = in_i;
                if (full_o) ovf_d = 1'b1;
                else        push  = 1'b1;
            end
            ACT_RET: begin
                if (empty_o) begin
                    unf_d = 1'b1;
                end else begin
                    out_d = top_o;
                    pop   = 1'b1;
                end
            end
            ACT_INC: out_d = ret_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_q <= RESET_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_ras (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ret_addr),
        .top_o   (top_o),
        .depth_o (depth_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    assign out_o = out_q;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;

endmodule
